// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and pointer type for the read-side FIFO.
package fifo_pkg;

    localparam int FIFO_ADDRBIT = 5;
    localparam int FIFO_DEPTH   = 32;
    localparam int DATA_WIDTH   = 12;

    typedef logic [FIFO_ADDRBIT:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer register: ADDRBIT+1 bits, synchronous clear beats increment.
module fifo_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int ADDRBIT = FIFO_ADDRBIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [ADDRBIT:0] ptr
);

    logic [ADDRBIT:0] ptr_q, ptr_d;

    // All-ones wraps to zero naturally and the extra MSB toggles.
    always_comb begin
        ptr_d = ptr_q;
        if (clr)
            ptr_d = '0;
        else if (inc)
            ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read-side FIFO pointer/flag controller. Optional almost_full/almost_empty
// watermarks are built when FIFO_PTR_CTRL_WATERMARK_EN is defined.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRBIT    = FIFO_ADDRBIT,
    parameter int FIFO_DEPTH = fifo_pkg::FIFO_DEPTH,
    parameter int AFULL_TH   = 28,
    parameter int AEMPTY_TH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_en,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic               clr_err,
    output logic               write_en,
    output logic               read_en,
    output logic [ADDRBIT-1:0] wraddr,
    output logic [ADDRBIT-1:0] rdaddr,
    output logic               fifofull,
    output logic               notempty,
    output logic [ADDRBIT:0]   count,
    output logic               overflow,
    output logic               underflow,
    output logic               almost_full,
    output logic               almost_empty
);

    if (FIFO_DEPTH != (1 << ADDRBIT)) begin : g_depth_chk
        $error("fifo_ptr_ctrl: FIFO_DEPTH must equal 2**ADDRBIT");
    end
    if (AFULL_TH > FIFO_DEPTH || AEMPTY_TH > FIFO_DEPTH) begin : g_th_chk
        $error("fifo_ptr_ctrl: watermark thresholds exceed FIFO_DEPTH");
    end

    logic [ADDRBIT:0] wr_ptr, rd_ptr;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_set, udf_set;

    fifo_ptr_cnt #(.ADDRBIT(ADDRBIT)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (write_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr_cnt #(.ADDRBIT(ADDRBIT)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (read_en),
        .ptr   (rd_ptr)
    );

    assign fifofull = (wr_ptr[ADDRBIT] != rd_ptr[ADDRBIT]) &&
                      (wr_ptr[ADDRBIT-1:0] == rd_ptr[ADDRBIT-1:0]);
    assign notempty = (wr_ptr != rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign wraddr   = wr_ptr[ADDRBIT-1:0];
    assign rdaddr   = rd_ptr[ADDRBIT-1:0];

    // Flush squashes the memory strobes but not error detection.
    assign write_en = fifo_en & push & ~fifofull & ~flush;
    assign read_en  = fifo_en & pop & notempty & ~flush;
    assign ovf_set  = fifo_en & push & fifofull;
    assign udf_set  = fifo_en & pop & ~notempty;

    always_comb begin
        overflow_d  = ovf_set | (overflow_q & ~clr_err);
        underflow_d = udf_set | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_PTR_CTRL_WATERMARK_EN
    localparam logic [ADDRBIT:0] AFULL_V  = AFULL_TH[ADDRBIT:0];
    localparam logic [ADDRBIT:0] AEMPTY_V = AEMPTY_TH[ADDRBIT:0];
    assign almost_full  = (count >= AFULL_V);
    assign almost_empty = (count <= AEMPTY_V);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: stimulus queues expected results,
// a monitor pops and compares them every issued cycle.
module tb_fifo_ptr_ctrl;

    localparam int AB    = 5;
    localparam int DEPTH = 32;
    localparam int AF_TH = 28;
    localparam int AE_TH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_en = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic          write_en, read_en, fifofull, notempty, overflow, underflow;
    logic          almost_full, almost_empty;
    logic [AB-1:0] wraddr, rdaddr;
    logic [AB:0]   count;

    fifo_ptr_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_en      (fifo_en),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .clr_err      (clr_err),
        .write_en     (write_en),
        .read_en      (read_en),
        .wraddr       (wraddr),
        .rdaddr       (rdaddr),
        .fifofull     (fifofull),
        .notempty     (notempty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we, re;
        int   wa, ra, cnt;
        logic full, ne, ovf, udf, af, ae;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: occupancy and addresses tracked as plain integers.
    int   m_occ = 0, m_wa = 0, m_ra = 0;
    logic m_ovf = 0, m_udf = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic wm_af(input int occ);
`ifdef FIFO_PTR_CTRL_WATERMARK_EN
        return occ >= AF_TH;
`else
        return (occ < 0);
`endif
    endfunction

    function automatic logic wm_ae(input int occ);
`ifdef FIFO_PTR_CTRL_WATERMARK_EN
        return occ <= AE_TH;
`else
        return (occ < 0);
`endif
    endfunction

    task automatic step(input logic en, input logic fl, input logic pu, input logic po,
                        input logic cl);
        exp_t e;
        logic full, ne;
        @(negedge clk);
        fifo_en = en; flush = fl; push = pu; pop = po; clr_err = cl;
        full = (m_occ == DEPTH);
        ne   = (m_occ != 0);
        e.we = en & pu & ~full & ~fl;
        e.re = en & po & ne & ~fl;
        m_ovf = (en & pu & full) | (m_ovf & ~cl);
        m_udf = (en & po & ~ne) | (m_udf & ~cl);
        if (fl) begin
            m_occ = 0; m_wa = 0; m_ra = 0;
        end else begin
            m_occ = m_occ + int'(e.we) - int'(e.re);
            m_wa  = (m_wa + int'(e.we)) % DEPTH;
            m_ra  = (m_ra + int'(e.re)) % DEPTH;
        end
        e.wa = m_wa; e.ra = m_ra; e.cnt = m_occ;
        e.full = (m_occ == DEPTH); e.ne = (m_occ != 0);
        e.ovf = m_ovf; e.udf = m_udf;
        e.af = wm_af(m_occ); e.ae = wm_ae(m_occ);
        q.push_back(e);
    endtask

    // Monitor: strobes checked mid-low-phase, state checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() == 0) continue;
            e = q.pop_front();
            chk("write_en", int'(write_en), int'(e.we));
            chk("read_en", int'(read_en), int'(e.re));
            @(posedge clk);
            #1;
            chk("wraddr", int'(wraddr), e.wa);
            chk("rdaddr", int'(rdaddr), e.ra);
            chk("count", int'(count), e.cnt);
            chk("fifofull", int'(fifofull), int'(e.full));
            chk("notempty", int'(notempty), int'(e.ne));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.udf));
            chk("almost_full", int'(almost_full), int'(e.af));
            chk("almost_empty", int'(almost_empty), int'(e.ae));
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_wraddr"}, int'(wraddr), 0);
        chk({tag, "_rdaddr"}, int'(rdaddr), 0);
        chk({tag, "_fifofull"}, int'(fifofull), 0);
        chk({tag, "_notempty"}, int'(notempty), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_checks("rst");
        @(negedge clk) rst_n = 1'b1;

        // Fill to full, then overflow attempts.
        for (int i = 0; i < 32; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);            // push while full
        step(1, 0, 1, 0, 1);            // set beats clr_err
        step(1, 0, 0, 0, 1);            // clear overflow
        step(1, 0, 1, 1, 0);            // full+push+pop: pop only, overflow
        step(1, 0, 1, 0, 1);            // refill last slot, clear

        // Drain to empty, then underflow attempts.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);            // pop while empty
        step(1, 0, 1, 1, 1);            // empty+push+pop: push only, underflow kept
        step(1, 0, 0, 0, 1);

        // Build count=10, then steady push+pop with pointer wrap.
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 1, 1, 0);

        // Down to 5, flush with push+pop, then fifo_en low.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);            // no underflow with fifo_en low
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);            // held pointers, non-empty flags
        step(0, 1, 0, 0, 0);            // flush works with fifo_en low

        // Async reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);            // underflow-free pop, leaves count 2
        step(1, 0, 1, 1, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 reset_checks("async_rst");
        m_occ = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
        @(negedge clk);
        fifo_en = 0; push = 0; pop = 0; flush = 0; clr_err = 0;
        rst_n = 1'b1;
        step(1, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d scoreboard entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
